// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the TDC FIFO word format. The TDC block packs words
// with these constants and tdc_fifo_reader unpacks them.
//   Word layout : [31:28] data identifier, [27:16] TDC count, [15:0] raw ts
//   Event record: {tdc[11:0], ts[31:0]}, where ts = {wrap count, raw ts}
// -----------------------------------------------------------------------------
package tdc_pkg;

  localparam int TDC_ID_MSB  = 31;
  localparam int TDC_ID_LSB  = 28;
  localparam int TDC_VAL_MSB = 27;
  localparam int TDC_VAL_LSB = 16;
  localparam int TDC_TS_MSB  = 15;
  localparam int TDC_TS_LSB  = 0;

  localparam logic [3:0] TDC_DEFAULT_ID = 4'b0100;

  typedef struct packed {
    logic [11:0] tdc;
    logic [31:0] ts;
  } tdc_event_t;

  localparam int TDC_EVT_W = $bits(tdc_event_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  // Builds one FIFO word; used on the producer side.
  function automatic logic [31:0] tdc_pack(input logic [3:0]  id,
                                           input logic [11:0] tdc,
                                           input logic [15:0] ts);
    return {id, tdc, ts};
  endfunction

endpackage

// File: rtl/tdc_skid_buffer.sv
// -----------------------------------------------------------------------------
// tdc_skid_buffer
// Two-entry valid/ready buffer. Entry _p0 is the head and drives out_data
// directly, so the output is registered and does not change while the sink
// stalls. Push and pop in the same cycle keep the occupancy unchanged.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties buffer)
//   in_valid/ready  write side; in_ready is low only when both entries full
//   in_data         DATA_W payload
//   out_valid/ready read side
//   out_data        head payload (undefined while out_valid = 0)
// -----------------------------------------------------------------------------
module tdc_skid_buffer #(
  parameter int DATA_W = 44
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [1:0]        cnt;
  logic [DATA_W-1:0] entry_p0;
  logic [DATA_W-1:0] entry_p1;
  logic              push;
  logic              pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = entry_p0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
    end else if (push && !pop) begin
      cnt <= cnt + 2'd1;
    end else if (pop && !push) begin
      cnt <= cnt - 2'd1;
    end
  end

  // Payload registers carry no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push && pop) begin
      if (cnt == 2'd1) begin
        entry_p0 <= in_data;
      end else begin
        entry_p0 <= entry_p1;
        entry_p1 <= in_data;
      end
    end else if (push) begin
      if (cnt == 2'd0) begin
        entry_p0 <= in_data;
      end else begin
        entry_p1 <= in_data;
      end
    end else if (pop) begin
      entry_p0 <= entry_p1;
    end
  end

endmodule

// File: rtl/tdc_fifo_reader.sv
// -----------------------------------------------------------------------------
// tdc_fifo_reader
// Pops 32-bit words from the first-word-fall-through TDC FIFO, drops words
// whose identifier is wrong, extends the 16-bit timestamp with a wrap counter
// and hands decoded events to a valid/ready sink through a 2-entry buffer.
// Ports:
//   BUS_CLK, BUS_RST     clock, asynchronous active-high reset
//   EN                   enables popping (IDLE -> RUN, RUN -> DRAIN when low)
//   CLEAR                sync pulse: clears counters and wrap state
//   FIFO_EMPTY/DATA/READ FWFT FIFO interface; FIFO_READ is the pop strobe
//   OUT_VALID/READY      event handshake
//   OUT_TDC, OUT_TIMESTAMP  decoded event (zero while OUT_VALID = 0)
//   WORD_CNT, ID_ERR_CNT saturating status counters
//   BUSY                 state machine not idle
// -----------------------------------------------------------------------------
module tdc_fifo_reader
  import tdc_pkg::*;
#(
  parameter logic [3:0] DATA_IDENTIFIER = TDC_DEFAULT_ID,
  parameter int         CNT_WIDTH       = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 EN,
  input  logic                 CLEAR,
  input  logic                 FIFO_EMPTY,
  input  logic [31:0]          FIFO_DATA,
  output logic                 FIFO_READ,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [11:0]          OUT_TDC,
  output logic [31:0]          OUT_TIMESTAMP,
  output logic [CNT_WIDTH-1:0] WORD_CNT,
  output logic [CNT_WIDTH-1:0] ID_ERR_CNT,
  output logic                 BUSY
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  rd_state_t  state;
  rd_state_t  state_nxt;

  logic       buf_in_ready;
  logic       buf_out_valid;
  logic [TDC_EVT_W-1:0] buf_out_data;
  tdc_event_t evt_in;
  tdc_event_t evt_out;

  logic        pop;
  logic        id_ok;
  logic        push;
  logic [15:0] raw_ts;
  logic [15:0] last_ts;
  logic [15:0] wrap_cnt;
  logic [15:0] wrap_use;
  logic        first_seen;
  logic        wrap_inc;

  logic [CNT_WIDTH-1:0] word_base;
  logic [CNT_WIDTH-1:0] err_base;

  // ---------------------------------------------------------------------------
  // Pop decision and word decode (combinational, same cycle as FIFO_READ)
  // ---------------------------------------------------------------------------
  assign FIFO_READ = (state == ST_RUN) & ~FIFO_EMPTY & buf_in_ready;
  assign pop       = FIFO_READ;
  assign id_ok     = (FIFO_DATA[TDC_ID_MSB:TDC_ID_LSB] == DATA_IDENTIFIER);
  assign push      = pop & id_ok;
  assign raw_ts    = FIFO_DATA[TDC_TS_MSB:TDC_TS_LSB];

  // A CLEAR in the pop cycle wins over the wrap state: the word is assembled
  // with a zero wrap count and the word after it is still treated as the
  // first one, so it can never register a wrap against a pre-clear value.
  assign wrap_inc = first_seen & (raw_ts < last_ts) & ~CLEAR;
  assign wrap_use = CLEAR    ? 16'd0 :
                    wrap_inc ? wrap_cnt + 16'd1 : wrap_cnt;

  assign evt_in.tdc = FIFO_DATA[TDC_VAL_MSB:TDC_VAL_LSB];
  assign evt_in.ts  = {wrap_use, raw_ts};

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      wrap_cnt   <= 16'd0;
      first_seen <= 1'b0;
    end else if (CLEAR) begin
      wrap_cnt   <= 16'd0;
      first_seen <= 1'b0;
    end else if (push) begin
      wrap_cnt   <= wrap_use;
      first_seen <= 1'b1;
    end
  end

  // Only meaningful once first_seen is set, so it needs no reset.
  always_ff @(posedge BUS_CLK) begin
    if (push && !CLEAR) begin
      last_ts <= raw_ts;
    end
  end

  // ---------------------------------------------------------------------------
  // Status counters (clear first, then count this cycle's pop)
  // ---------------------------------------------------------------------------
  assign word_base = CLEAR ? '0 : WORD_CNT;
  assign err_base  = CLEAR ? '0 : ID_ERR_CNT;

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      WORD_CNT   <= '0;
      ID_ERR_CNT <= '0;
    end else begin
      WORD_CNT   <= pop ? sat_inc(word_base) : word_base;
      ID_ERR_CNT <= (pop && !id_ok) ? sat_inc(err_base) : err_base;
    end
  end

  // ---------------------------------------------------------------------------
  // Event buffer and output stage
  // ---------------------------------------------------------------------------
  tdc_skid_buffer #(
    .DATA_W (TDC_EVT_W)
  ) u_skid (
    .clk       (BUS_CLK),
    .rst       (BUS_RST),
    .in_valid  (push),
    .in_ready  (buf_in_ready),
    .in_data   (evt_in),
    .out_valid (buf_out_valid),
    .out_ready (OUT_READY),
    .out_data  (buf_out_data)
  );

  assign evt_out       = buf_out_data;
  assign OUT_VALID     = buf_out_valid;
  assign OUT_TDC       = buf_out_valid ? evt_out.tdc : 12'd0;
  assign OUT_TIMESTAMP = buf_out_valid ? evt_out.ts  : 32'd0;

  // ---------------------------------------------------------------------------
  // Control state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (EN) state_nxt = ST_RUN;
      ST_RUN:   if (!EN) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (EN) begin
          state_nxt = ST_RUN;
        end else if (!buf_out_valid) begin
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_tdc_fifo_reader.sv
module tb_tdc_fifo_reader;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST;
  logic        EN;
  logic        CLEAR;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic        FIFO_READ;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [11:0] OUT_TDC;
  logic [31:0] OUT_TIMESTAMP;
  logic [15:0] WORD_CNT;
  logic [15:0] ID_ERR_CNT;
  logic        BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 BUS_CLK = ~BUS_CLK;

  tdc_fifo_reader #(
    .DATA_IDENTIFIER (4'b0100),
    .CNT_WIDTH       (16)
  ) dut (
    .BUS_CLK       (BUS_CLK),
    .BUS_RST       (BUS_RST),
    .EN            (EN),
    .CLEAR         (CLEAR),
    .FIFO_EMPTY    (FIFO_EMPTY),
    .FIFO_DATA     (FIFO_DATA),
    .FIFO_READ     (FIFO_READ),
    .OUT_VALID     (OUT_VALID),
    .OUT_READY     (OUT_READY),
    .OUT_TDC       (OUT_TDC),
    .OUT_TIMESTAMP (OUT_TIMESTAMP),
    .WORD_CNT      (WORD_CNT),
    .ID_ERR_CNT    (ID_ERR_CNT),
    .BUSY          (BUSY)
  );

  // FWFT FIFO model
  logic [31:0] mem [0:63];
  logic [5:0]  wr_ptr = 6'd0;
  logic [5:0]  rd_ptr = 6'd0;
  assign FIFO_EMPTY = (rd_ptr == wr_ptr);
  assign FIFO_DATA  = mem[rd_ptr];

  int pop_cnt      = 0;
  int spurious_cnt = 0;
  logic [43:0] ev_q [$];

  always @(posedge BUS_CLK) begin
    if (FIFO_READ) begin
      if (FIFO_EMPTY) spurious_cnt <= spurious_cnt + 1;
      else rd_ptr <= rd_ptr + 6'd1;
      pop_cnt <= pop_cnt + 1;
    end
    if (OUT_VALID && OUT_READY) ev_q.push_back({OUT_TDC, OUT_TIMESTAMP});
  end

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic test_reset;
    BUS_RST = 1'b1; EN = 1'b0; CLEAR = 1'b0; OUT_READY = 1'b0;
    repeat (2) @(negedge BUS_CLK);
    n_checks++; if (FIFO_READ !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_read: got %b want 0", FIFO_READ); end
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", OUT_VALID); end
    n_checks++; if (OUT_TDC !== 12'h000) begin n_fail++; $display("FAIL rst_out_tdc: got %h want 000", OUT_TDC); end
    n_checks++; if (OUT_TIMESTAMP !== 32'h0) begin n_fail++; $display("FAIL rst_out_ts: got %h want 0", OUT_TIMESTAMP); end
    n_checks++; if (WORD_CNT !== 16'h0) begin n_fail++; $display("FAIL rst_word_cnt: got %h want 0", WORD_CNT); end
    n_checks++; if (ID_ERR_CNT !== 16'h0) begin n_fail++; $display("FAIL rst_err_cnt: got %h want 0", ID_ERR_CNT); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    BUS_RST = 1'b0;
    @(negedge BUS_CLK);
  endtask

  task automatic test_basic;
    logic [11:0] et [3];
    logic [31:0] ets [3];
    et  = '{12'hABC, 12'h123, 12'h001};
    ets = '{32'h00000010, 32'h0000FFF0, 32'h00010005};
    OUT_READY = 1'b1;
    EN = 1'b1;
    @(negedge BUS_CLK);
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", BUSY); end
    push_word(32'h4ABC0010);
    push_word(32'h4123FFF0);
    push_word(32'h40010005);
    #1;
    n_checks++; if (FIFO_READ !== 1'b1) begin n_fail++; $display("FAIL basic_read: got %b want 1", FIFO_READ); end
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL basic_valid0: got %b want 0", OUT_VALID); end
    for (int i = 0; i < 3; i++) begin
      @(negedge BUS_CLK);
      n_checks++;
      if (OUT_VALID !== 1'b1 || OUT_TDC !== et[i] || OUT_TIMESTAMP !== ets[i]) begin
        n_fail++;
        $display("FAIL basic_event%0d: got v=%b tdc=%h ts=%h want v=1 tdc=%h ts=%h",
                 i, OUT_VALID, OUT_TDC, OUT_TIMESTAMP, et[i], ets[i]);
      end
    end
    @(negedge BUS_CLK);
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL basic_valid_end: got %b want 0", OUT_VALID); end
    n_checks++; if (WORD_CNT !== 16'd3) begin n_fail++; $display("FAIL basic_word_cnt: got %0d want 3", WORD_CNT); end
  endtask

  task automatic test_id_err;
    int base;
    int t;
    base = ev_q.size();
    push_word(32'h40020100);
    push_word(32'h7FFF1234);
    push_word(32'h40030200);
    t = 0;
    while (ev_q.size() < base + 2 && t < 30) begin @(negedge BUS_CLK); t++; end
    repeat (2) @(negedge BUS_CLK);
    n_checks++;
    if (ev_q.size() != base + 2) begin
      n_fail++; $display("FAIL iderr_event_count: got %0d want %0d", ev_q.size() - base, 2);
    end else begin
      n_checks++; if (ev_q[base] !== {12'h002, 32'h00010100}) begin n_fail++; $display("FAIL iderr_ev0: got %h want %h", ev_q[base], {12'h002, 32'h00010100}); end
      n_checks++; if (ev_q[base+1] !== {12'h003, 32'h00010200}) begin n_fail++; $display("FAIL iderr_ev1: got %h want %h", ev_q[base+1], {12'h003, 32'h00010200}); end
    end
    n_checks++; if (WORD_CNT !== 16'd6) begin n_fail++; $display("FAIL iderr_word_cnt: got %0d want 6", WORD_CNT); end
    n_checks++; if (ID_ERR_CNT !== 16'd1) begin n_fail++; $display("FAIL iderr_err_cnt: got %0d want 1", ID_ERR_CNT); end
  endtask

  task automatic test_backpressure;
    int p0;
    int base;
    logic [43:0] exp;
    OUT_READY = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) push_word({4'h4, 12'(12'h100 + i), 16'(16'h1000 + i)});
    repeat (6) @(negedge BUS_CLK);
    n_checks++; if (pop_cnt - p0 != 2) begin n_fail++; $display("FAIL bp_pops: got %0d want 2", pop_cnt - p0); end
    n_checks++; if (FIFO_READ !== 1'b0) begin n_fail++; $display("FAIL bp_read_low: got %b want 0", FIFO_READ); end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (OUT_VALID !== 1'b1 || OUT_TDC !== 12'h100 || OUT_TIMESTAMP !== 32'h00011000) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b tdc=%h ts=%h want v=1 tdc=100 ts=00011000", k, OUT_VALID, OUT_TDC, OUT_TIMESTAMP);
      end
      @(negedge BUS_CLK);
    end
    OUT_READY = 1'b1;
    base = ev_q.size();
    repeat (10) @(negedge BUS_CLK);
    n_checks++;
    if (ev_q.size() != base + 10) begin
      n_fail++; $display("FAIL bp_rate: got %0d events in 10 cycles want 10", ev_q.size() - base);
    end else begin
      for (int i = 0; i < 10; i++) begin
        exp = {12'(12'h100 + i), 32'(32'h00011000 + i)};
        n_checks++;
        if (ev_q[base+i] !== exp) begin n_fail++; $display("FAIL bp_order%0d: got %h want %h", i, ev_q[base+i], exp); end
      end
    end
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_valid_end: got %b want 0", OUT_VALID); end
    n_checks++; if (pop_cnt - p0 != 10) begin n_fail++; $display("FAIL bp_total_pops: got %0d want 10", pop_cnt - p0); end
  endtask

  task automatic test_drain;
    int p0;
    int base;
    int t;
    logic [43:0] exp;
    OUT_READY = 1'b0;
    p0 = pop_cnt;
    base = ev_q.size();
    for (int i = 0; i < 4; i++) push_word({4'h4, 12'(12'h200 + i), 16'(16'h2000 + i)});
    repeat (4) @(negedge BUS_CLK);
    EN = 1'b0;
    @(negedge BUS_CLK);
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL drain_busy_hold: got %b want 1", BUSY); end
    n_checks++; if (pop_cnt - p0 != 2) begin n_fail++; $display("FAIL drain_pops: got %0d want 2", pop_cnt - p0); end
    OUT_READY = 1'b1;
    repeat (2) @(negedge BUS_CLK);
    n_checks++; if (ev_q.size() - base != 2) begin n_fail++; $display("FAIL drain_accepted: got %0d want 2", ev_q.size() - base); end
    n_checks++; if (BUSY !== 1'b1 || OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL drain_last: got busy=%b v=%b want busy=1 v=0", BUSY, OUT_VALID); end
    @(negedge BUS_CLK);
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got %b want 0", BUSY); end
    repeat (3) @(negedge BUS_CLK);
    n_checks++; if (pop_cnt - p0 != 2 || FIFO_READ !== 1'b0) begin n_fail++; $display("FAIL drain_no_pop: got pops=%0d rd=%b want 2 0", pop_cnt - p0, FIFO_READ); end
    EN = 1'b1;
    t = 0;
    while (ev_q.size() < base + 4 && t < 30) begin @(negedge BUS_CLK); t++; end
    n_checks++;
    if (ev_q.size() != base + 4) begin
      n_fail++; $display("FAIL drain_resume: got %0d events want 4", ev_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = {12'(12'h200 + i), 32'(32'h00012000 + i)};
        n_checks++;
        if (ev_q[base+i] !== exp) begin n_fail++; $display("FAIL drain_ev%0d: got %h want %h", i, ev_q[base+i], exp); end
      end
    end
  endtask

  task automatic test_clear;
    int base;
    int t;
    @(negedge BUS_CLK);
    base = ev_q.size();
    push_word(32'h45558000);
    CLEAR = 1'b1;
    @(negedge BUS_CLK);
    CLEAR = 1'b0;
    n_checks++; if (WORD_CNT !== 16'd1) begin n_fail++; $display("FAIL clr_word_cnt: got %0d want 1", WORD_CNT); end
    n_checks++; if (ID_ERR_CNT !== 16'd0) begin n_fail++; $display("FAIL clr_err_cnt: got %0d want 0", ID_ERR_CNT); end
    n_checks++;
    if (OUT_VALID !== 1'b1 || OUT_TDC !== 12'h555 || OUT_TIMESTAMP !== 32'h00008000) begin
      n_fail++; $display("FAIL clr_event: got v=%b tdc=%h ts=%h want v=1 tdc=555 ts=00008000", OUT_VALID, OUT_TDC, OUT_TIMESTAMP);
    end
    push_word(32'h46660100);
    push_word(32'h47770050);
    t = 0;
    while (ev_q.size() < base + 3 && t < 30) begin @(negedge BUS_CLK); t++; end
    n_checks++;
    if (ev_q.size() != base + 3) begin
      n_fail++; $display("FAIL clr_events: got %0d want 3", ev_q.size() - base);
    end else begin
      n_checks++; if (ev_q[base+1] !== {12'h666, 32'h00000100}) begin n_fail++; $display("FAIL clr_no_wrap: got %h want %h", ev_q[base+1], {12'h666, 32'h00000100}); end
      n_checks++; if (ev_q[base+2] !== {12'h777, 32'h00010050}) begin n_fail++; $display("FAIL clr_wrap: got %h want %h", ev_q[base+2], {12'h777, 32'h00010050}); end
    end
    n_checks++; if (WORD_CNT !== 16'd3) begin n_fail++; $display("FAIL clr_word_cnt2: got %0d want 3", WORD_CNT); end
  endtask

  task automatic test_async_reset;
    OUT_READY = 1'b0;
    push_word(32'h48880001);
    repeat (2) @(negedge BUS_CLK);
    n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b want 1", OUT_VALID); end
    #2 BUS_RST = 1'b1;
    #1;
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", OUT_VALID); end
    n_checks++; if (OUT_TDC !== 12'h0 || OUT_TIMESTAMP !== 32'h0) begin n_fail++; $display("FAIL arst_out: got tdc=%h ts=%h want 0 0", OUT_TDC, OUT_TIMESTAMP); end
    n_checks++; if (WORD_CNT !== 16'd0 || ID_ERR_CNT !== 16'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d %0d want 0 0", WORD_CNT, ID_ERR_CNT); end
    n_checks++; if (BUSY !== 1'b0 || FIFO_READ !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl: got busy=%b rd=%b want 0 0", BUSY, FIFO_READ); end
    @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    repeat (2) @(negedge BUS_CLK);
    n_checks++; if (spurious_cnt != 0) begin n_fail++; $display("FAIL no_spurious_read: got %0d want 0", spurious_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_id_err();
    test_backpressure();
    test_drain();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
